// File: rtl/approx_mult_pkg.sv
// Shared constants and elaboration helpers for the approximate multiplier pipeline.
package approx_mult_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Bit width of one sub-product held in tree level k (level 0 holds 4-bit tiles).
  function automatic int stage_width(input int k);
    return 4 << k;
  endfunction

endpackage

// File: rtl/approx_kernel_2x2.sv
// 2x2-bit multiplier tile. Approximate mode drops the carry of the 3x3 case,
// which yields 7 instead of 9; every other digit pair is exact.
module approx_kernel_2x2
  import approx_mult_pkg::*;
(
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       approx,
  output logic [3:0] r
);

  logic [3:0] exact_r;
  logic [3:0] approx_r;

  assign exact_r  = {2'b00, x} * {2'b00, y};
  assign approx_r = {1'b0,
                     x[1] & y[1],
                     (x[1] & y[0]) | (x[0] & y[1]),
                     x[0] & y[0]};
  assign r = (approx == MODE_APPROX) ? approx_r : exact_r;

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned multiplier built as a tree of 2x2 tiles.
// Level 0 registers all tile products; every further level merges groups of
// four sub-products into one of twice the width. Each level has its own
// enable so bubbles are squeezed out under backpressure.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter  int N     = 16,
  parameter  int TAG_W = 4,
  localparam int LAT   = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_approx,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic             out_approx,
  output logic [TAG_W-1:0] out_tag
);

  // Number of 2-bit digits per operand.
  localparam int D = N / 2;

  logic [LAT-1:0]            en;
  logic [LAT-1:0]            v_q;
  logic [LAT-1:0]            v_d;
  logic [LAT-1:0]            mode_q;
  logic [LAT-1:0]            mode_d;
  logic [LAT-1:0][TAG_W-1:0] tag_q;
  logic [LAT-1:0][TAG_W-1:0] tag_d;

  // Enable chain from the output back to the input: a level may load when it
  // is empty or when the level after it is itself moving.
  always_comb begin
    logic run;
    en  = '0;
    run = out_ready | ~v_q[LAT-1];
    for (int k = LAT - 1; k >= 0; k--) begin
      if (k < LAT - 1) run = ~v_q[k] | run;
      en[k] = run;
    end
  end

  // Upstream view of each level: the input port for level 0, the previous level otherwise.
  always_comb begin
    v_d       = '0;
    mode_d    = '0;
    tag_d     = '0;
    v_d[0]    = in_valid;
    mode_d[0] = in_approx;
    tag_d[0]  = in_tag;
    for (int k = 1; k < LAT; k++) begin
      v_d[k]    = v_q[k-1];
      mode_d[k] = mode_q[k-1];
      tag_d[k]  = tag_q[k-1];
    end
  end

  // Valid, mode and tag advance with their level; sideband only loads with a real beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      mode_q <= '0;
      tag_q  <= '0;
    end else begin
      for (int k = 0; k < LAT; k++) begin
        if (en[k]) begin
          v_q[k] <= v_d[k];
          if (v_d[k]) begin
            mode_q[k] <= mode_d[k];
            tag_q[k]  <= tag_d[k];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < LAT; k++) begin : g_lvl
    localparam int W  = stage_width(k);
    localparam int DK = D >> k;

    // Sub-product (i, j) covers digit group i of a and digit group j of b,
    // stored at slot i*DK + j.
    logic [W*DK*DK-1:0] prod_d;
    logic [W*DK*DK-1:0] prod_q;

    if (k == 0) begin : g_tiles
      for (genvar i = 0; i < D; i++) begin : g_row
        for (genvar j = 0; j < D; j++) begin : g_col
          approx_kernel_2x2 u_kernel (
            .x      (in_a[2*i +: 2]),
            .y      (in_b[2*j +: 2]),
            .approx (in_approx),
            .r      (prod_d[(i*D + j)*4 +: 4])
          );
        end
      end
    end else begin : g_tree
      localparam int WP = W / 2;
      localparam int DP = 2 * DK;
      for (genvar i = 0; i < DK; i++) begin : g_row
        for (genvar j = 0; j < DK; j++) begin : g_col
          logic [WP-1:0] ll;
          logic [WP-1:0] hl;
          logic [WP-1:0] lh;
          logic [WP-1:0] hh;
          assign ll = g_lvl[k-1].prod_q[((2*i)*DP   + 2*j)*WP   +: WP];
          assign hl = g_lvl[k-1].prod_q[((2*i+1)*DP + 2*j)*WP   +: WP];
          assign lh = g_lvl[k-1].prod_q[((2*i)*DP   + 2*j+1)*WP +: WP];
          assign hh = g_lvl[k-1].prod_q[((2*i+1)*DP + 2*j+1)*WP +: WP];
          // Full-width sum; the product of two WP/2-bit groups always fits W bits.
          assign prod_d[(i*DK + j)*W +: W] = W'(ll)
                                           + (W'(hl) << (WP/2))
                                           + (W'(lh) << (WP/2))
                                           + (W'(hh) << WP);
        end
      end
    end

    // Product register for this level; holds while stalled or fed a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
      end else if (en[k] && v_d[k]) begin
        prod_q <= prod_d;
      end
    end
  end

  assign in_ready   = en[0];
  assign out_valid  = v_q[LAT-1];
  assign out_approx = mode_q[LAT-1];
  assign out_tag    = tag_q[LAT-1];
  assign out_p      = g_lvl[LAT-1].prod_q;

endmodule
